debug_step_ctrl: RTL and testbench

//  Successor debug stepper. Drives a clock enable (sys_ce) instead of a gated clock.

---
 rtl/debug_step_ctrl.sv | 144 ++++++++++++++
 tb/tb_debug_step_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: debug stepper driving a pipeline clock enable.
// Supports free run, halt, N-cycle stepping, a cycle-counter breakpoint
// and a snapshot of the debug buses taken on every halt entry.
module debug_step_ctrl #(
    parameter int CNT_WIDTH  = 16,
    parameter int STEP_WIDTH = 8,
    parameter int DEBUG_SIZE = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             phy_clk,
    input  logic                             reset_n,
    input  logic                             debug_enable,
    input  logic                             step_req,
    input  logic [STEP_WIDTH-1:0]            step_count,
    input  logic                             bp_enable,
    input  logic [CNT_WIDTH-1:0]             bp_value,
    input  logic [DEBUG_SIZE*DATA_WIDTH-1:0] debug_in,
    output logic                             sys_ce,
    output logic [CNT_WIDTH-1:0]             clock_counter,
    output logic                             halted,
    output logic                             bp_hit,
    output logic                             snap_valid,
    output logic [DEBUG_SIZE*DATA_WIDTH-1:0] debug_snap
);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
    logic [STEP_WIDTH-1:0]           rem_q, rem_d;
    logic                            bp_hit_q, bp_hit_d;
    logic                            snap_valid_q, snap_valid_d;
    logic [DEBUG_SIZE*DATA_WIDTH-1:0] snap_q, snap_d;
    logic                            sync1_q, sync2_q, sync3_q;

    logic                            step_edge;
    logic [CNT_WIDTH-1:0]            cnt_inc;
    logic                            bp_match;
    logic                            run_en;

    assign run_en    = (state_q != HALT);
    assign step_edge = sync2_q & ~sync3_q;
    assign cnt_inc   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    // Fires only when the counter is about to step onto bp_value, so a
    // step taken while sitting on the breakpoint cannot re-trigger it.
    assign bp_match  = bp_enable && (cnt_inc == bp_value);

    // Synchronise the host step request and keep a delayed copy for edge detect.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= step_req;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Next-state, step counter, breakpoint flag and snapshot decisions.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        bp_hit_d     = bp_hit_q;
        snap_valid_d = snap_valid_q;
        snap_d       = snap_q;
        cnt_d        = run_en ? cnt_inc : cnt_q;

        unique case (state_q)
            HALT: begin
                if (!debug_enable) begin
                    state_d  = RUN;
                    bp_hit_d = 1'b0;
                end else if (step_edge) begin
                    state_d  = STEP;
                    rem_d    = (step_count == '0) ? STEP_WIDTH'(1) : step_count;
                    bp_hit_d = 1'b0;
                end
            end
            RUN: begin
                if (debug_enable) begin
                    state_d = HALT;
                end else if (bp_match) begin
                    state_d  = HALT;
                    bp_hit_d = 1'b1;
                end
            end
            STEP: begin
                rem_d = rem_q - STEP_WIDTH'(1);
                if (!debug_enable) begin
                    state_d = RUN;
                    rem_d   = '0;
                end else if (bp_match) begin
                    state_d  = HALT;
                    bp_hit_d = 1'b1;
                    rem_d    = '0;
                end else if (rem_q == STEP_WIDTH'(1)) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase

        // Capture the debug buses on halt entry; invalidate on leaving halt.
        if (state_q != HALT && state_d == HALT) begin
            snap_d       = debug_in;
            snap_valid_d = 1'b1;
        end else if (state_q == HALT && state_d != HALT) begin
            snap_valid_d = 1'b0;
        end
    end

    // State and datapath registers; reset parks the controller in HALT.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= HALT;
            cnt_q        <= '0;
            rem_q        <= '0;
            bp_hit_q     <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            bp_hit_q     <= bp_hit_d;
            snap_valid_q <= snap_valid_d;
            snap_q       <= snap_d;
        end
    end

    assign sys_ce        = run_en;
    assign clock_counter = cnt_q;
    assign halted        = (state_q == HALT);
    assign bp_hit        = bp_hit_q;
    assign snap_valid    = snap_valid_q;
    assign debug_snap    = snap_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed testbench for debug_step_ctrl with an expectation queue.
module tb_debug_step_ctrl;

    logic        phy_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        debug_enable = 1'b0;
    logic        step_req = 1'b0;
    logic [7:0]  step_count = 8'd0;
    logic        bp_enable = 1'b0;
    logic [15:0] bp_value = 16'd0;
    logic [63:0] debug_in = 64'd0;
    logic        sys_ce;
    logic [15:0] clock_counter;
    logic        halted;
    logic        bp_hit;
    logic        snap_valid;
    logic [63:0] debug_snap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    debug_step_ctrl #(
        .CNT_WIDTH (16),
        .STEP_WIDTH(8),
        .DEBUG_SIZE(4),
        .DATA_WIDTH(16)
    ) dut (
        .phy_clk      (phy_clk),
        .reset_n      (reset_n),
        .debug_enable (debug_enable),
        .step_req     (step_req),
        .step_count   (step_count),
        .bp_enable    (bp_enable),
        .bp_value     (bp_value),
        .debug_in     (debug_in),
        .sys_ce       (sys_ce),
        .clock_counter(clock_counter),
        .halted       (halted),
        .bp_hit       (bp_hit),
        .snap_valid   (snap_valid),
        .debug_snap   (debug_snap)
    );

    always #5 phy_clk = ~phy_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge phy_clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [63:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
        $display("check %-14s observed=%0h expected=%0h", e.tag, obs, e.val);
    endtask

    // Pulse step_req and count the sys_ce cycles the step produces.
    task automatic do_step(input logic [7:0] n, output int ce_cnt);
        step_count = n;
        step_req   = 1'b1;
        ce_cnt     = 0;
        for (int i = 0; i < 24; i++) begin
            tick(1);
            if (i == 3) step_req = 1'b0;
            if (sys_ce) ce_cnt++;
        end
    endtask

    // Run until halted; the host holds the halt by raising debug_enable.
    task automatic run_to_halt(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick(1);
            if (halted) begin
                debug_enable = 1'b1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ce(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick(1);
            if (sys_ce) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   ce_cnt;
        logic ok;

        // Reset state, then free run after one halted cycle.
        tick(2);
        expect_val("rst_halted", 64'd1);      check(64'(halted));
        expect_val("rst_ce", 64'd0);          check(64'(sys_ce));
        expect_val("rst_cnt", 64'd0);         check(64'(clock_counter));
        expect_val("rst_snapv", 64'd0);       check(64'(snap_valid));
        expect_val("rst_bphit", 64'd0);       check(64'(bp_hit));
        expect_val("rst_snap", 64'd0);        check(debug_snap);
        reset_n = 1'b1;
        expect_val("rel_ce0", 64'd0);         check(64'(sys_ce));
        tick(1);
        expect_val("rel_ce1", 64'd1);         check(64'(sys_ce));
        tick(10);
        expect_val("cnt_10", 64'd10);         check(64'(clock_counter));

        // Halt at counter 0x0010.
        tick(6);
        expect_val("cnt_0x10", 64'h10);       check(64'(clock_counter));
        debug_enable = 1'b1;
        debug_in = 64'h1111_2222_3333_4444;
        tick(1);
        expect_val("halt_now", 64'd1);        check(64'(halted));
        expect_val("halt_cnt", 64'h11);       check(64'(clock_counter));
        expect_val("halt_snapv", 64'd1);      check(64'(snap_valid));
        expect_val("halt_snap", 64'h1111_2222_3333_4444); check(debug_snap);
        debug_in = 64'hAAAA_BBBB_CCCC_DDDD;
        tick(3);
        expect_val("frozen_cnt", 64'h11);     check(64'(clock_counter));
        expect_val("frozen_snap", 64'h1111_2222_3333_4444); check(debug_snap);

        // Step of 5, then step_count 0 behaves as 1.
        do_step(8'd5, ce_cnt);
        expect_val("step5_ce", 64'd5);        check(64'(ce_cnt));
        expect_val("step5_cnt", 64'h16);      check(64'(clock_counter));
        expect_val("step5_halt", 64'd1);      check(64'(halted));
        expect_val("step5_snapv", 64'd1);     check(64'(snap_valid));
        expect_val("step5_snap", 64'hAAAA_BBBB_CCCC_DDDD); check(debug_snap);
        do_step(8'd0, ce_cnt);
        expect_val("step0_ce", 64'd1);        check(64'(ce_cnt));
        expect_val("step0_cnt", 64'h17);      check(64'(clock_counter));

        // Breakpoint at 0x0100 from reset, then step off it.
        reset_n = 1'b0;
        debug_enable = 1'b0;
        bp_enable = 1'b1;
        bp_value = 16'h0100;
        tick(1);
        reset_n = 1'b1;
        run_to_halt(400, ok);
        expect_val("bp_reached", 64'd1);      check(64'(ok));
        expect_val("bp_cnt", 64'h100);        check(64'(clock_counter));
        expect_val("bp_hit", 64'd1);          check(64'(bp_hit));
        expect_val("bp_snapv", 64'd1);        check(64'(snap_valid));
        do_step(8'd1, ce_cnt);
        expect_val("bpstep_ce", 64'd1);       check(64'(ce_cnt));
        expect_val("bpstep_cnt", 64'h101);    check(64'(clock_counter));
        expect_val("bpstep_hit", 64'd0);      check(64'(bp_hit));
        tick(5);
        expect_val("bp_noretrig", 64'h101);   check(64'(clock_counter));

        // Breakpoint at 0x0000 reached by wrapping the counter.
        reset_n = 1'b0;
        debug_enable = 1'b0;
        bp_value = 16'h0000;
        tick(1);
        reset_n = 1'b1;
        run_to_halt(70000, ok);
        expect_val("wrap_reached", 64'd1);    check(64'(ok));
        expect_val("wrap_cnt", 64'h0);        check(64'(clock_counter));
        expect_val("wrap_bphit", 64'd1);      check(64'(bp_hit));

        // Drop debug_enable mid-step with three cycles left.
        bp_enable = 1'b0;
        step_count = 8'd10;
        step_req = 1'b1;
        wait_ce(10, ok);
        expect_val("s6_step_go", 64'd1);      check(64'(ok));
        step_req = 1'b0;
        tick(7);
        debug_enable = 1'b0;
        tick(1);
        expect_val("s6_run_halt", 64'd0);     check(64'(halted));
        expect_val("s6_run_ce", 64'd1);       check(64'(sys_ce));
        tick(4);
        expect_val("s6_still_run", 64'd1);    check(64'(sys_ce));
        debug_enable = 1'b1;
        tick(1);
        expect_val("s6_rehalt", 64'd1);       check(64'(halted));

        // Reset pulse mid-step.
        tick(3);
        step_count = 8'd10;
        step_req = 1'b1;
        wait_ce(10, ok);
        expect_val("s6b_step_go", 64'd1);     check(64'(ok));
        step_req = 1'b0;
        tick(2);
        debug_enable = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        expect_val("mrst_halted", 64'd1);     check(64'(halted));
        expect_val("mrst_ce", 64'd0);         check(64'(sys_ce));
        expect_val("mrst_cnt", 64'd0);        check(64'(clock_counter));
        expect_val("mrst_snapv", 64'd0);      check(64'(snap_valid));
        tick(1);
        reset_n = 1'b1;
        expect_val("mrst_rel_ce0", 64'd0);    check(64'(sys_ce));
        tick(1);
        expect_val("mrst_rel_ce1", 64'd1);    check(64'(sys_ce));
        expect_val("mrst_rel_cnt", 64'd0);    check(64'(clock_counter));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
